cselect_seq_adder: RTL and testbench
====================================

# cselect_seq_adder

Multi-cycle wide-operand adder built around an 8-bit carry-select slice. It accepts one WIDTH-bit operand pair plus carry-in through a valid/ready handshake. It processes one SLICE-bit segment per clock, least significant first, and chains the registered carry between segments. It returns the full sum and carry-out through a second valid/ready handshake. It sits between an operand producer and a result consumer, replacing a full-width combinational carry-select adder where area matters more than latency.

## Interface
- WIDTH, 64, operand/sum width; must be a multiple of SLICE (elaboration error otherwise)
- SLICE, 8, bits added per cycle; N = WIDTH/SLICE segments
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  synchronous, active-high reset; one clock, synchronous reset active high
- in_valid  in  1  operand pair presented
- in_ready  out  1  block can accept operands (high only in IDLE)
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- cin  in  1  carry into bit 0
- out_valid  out  1  result available
- out_ready  in  1  consumer takes result
- sum  out  WIDTH  a + b + cin, modulo 2^WIDTH
- cout  out  1  carry out of bit WIDTH-1
- ovf  out  1  signed overflow (only with CSELECT_SEQ_OVF_EN)

## Operation
- States: IDLE, RUN, DONE. Reset state is IDLE.
- IDLE: in_ready=1. On in_valid&in_ready, latch a, b, cin into operand registers. Clear segment index k to 0 and go to RUN.
- RUN: each cycle computes segment k.
  - Compute s0 = a[k]+b[k]+0 and s1 = a[k]+b[k]+1 in parallel (carry-select).
  - The registered carry selects between them.
  - Write the selected SLICE bits into sum[k*SLICE +: SLICE] and register the segment carry-out as the next carry.
  - k increments. After segment N-1 completes, go to DONE.
- DONE: out_valid=1. sum, cout and ovf hold stable. On out_valid&out_ready, go to IDLE.
- in_ready=0 in RUN and DONE. in_valid in those states is ignored and has no effect on state.
- The sum register is not cleared between operations. Every bit is overwritten before out_valid rises.
- Arithmetic is unsigned modulo 2^WIDTH. cout is the carry out of the last segment.

## Timing
- Reset values: in_ready=0 while rst is high, and 1 on the first cycle after rst deasserts. out_valid=0, sum=0, cout=0, ovf=0, k=0.
- Latency: out_valid rises exactly N rising edges after the accepting edge. For the defaults this is 8 cycles.
- Result is held indefinitely under backpressure (out_ready low).
- Acceptance is not possible on the same edge as the output handshake. The next accept is at the earliest one cycle after out_valid falls.
- Maximum throughput is one operation per N+2 cycles.
- Reset in any state:
  - aborts the operation; no result is produced;
  - returns the block to IDLE with all outputs at their reset values on the next edge.
- Simultaneous rst and handshake: rst wins.

## Configuration
- CSELECT_SEQ_OVF_EN defined:
  - ovf port exists.
  - ovf = carry into bit WIDTH-1 XOR cout, captured when the last segment completes.
  - ovf is valid and stable with out_valid.
  - ovf is 0 after reset.
- Not defined: the ovf port and its carry-into-MSB register are absent. All other behaviour is identical.

## Test plan
- Reset: hold rst 3 cycles. During reset, in_ready=0. After release, in_ready=1, out_valid=0, sum=0, cout=0.
- Basic add: a=998, b=128, cin=0 accepted at edge T. Required: out_valid first high after edge T+8, sum=1126, cout=0.
- Full ripple: a=0xFFFF_FFFF_FFFF_FFFF, b=1, cin=0. Required: sum=0, cout=1, ovf=0. Then a=0, b=0, cin=1 gives sum=1, cout=0.
- Overflow (macro on): a=0x7FFF_FFFF_FFFF_FFFF, b=1. Required: sum=0x8000_0000_0000_0000, cout=0, ovf=1.
- Backpressure: hold out_ready low 5 cycles after out_valid rises, and drive in_valid with new operands meanwhile. Required:
  - sum, cout and out_valid stay stable;
  - in_ready stays 0;
  - the new operands are ignored.
  - When out_ready=1, out_valid drops the next cycle and in_ready returns to 1.
- Mid-operation reset: pulse rst during the 3rd RUN cycle. Required:
  - out_valid never rises;
  - outputs are 0;
  - in_ready=1 after release.
  - A following a=9998, b=9028 gives sum=19026, cout=0 after 8 cycles.

Source files
------------

// File: rtl/cselect_seq_adder.sv
// cselect_seq_adder: multi-cycle WIDTH-bit adder built from one SLICE-bit
// carry-select slice, one segment per clock, least significant first.
// Operands enter via in_valid/in_ready; the result leaves via out_valid/out_ready.
// Optional feature macro: CSELECT_SEQ_OVF_EN adds the signed-overflow output ovf.
module cselect_seq_adder #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned SLICE = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
`ifdef CSELECT_SEQ_OVF_EN
    output logic             ovf,
`endif
    output logic             cout
);

    localparam int unsigned SDIV = (SLICE == 0) ? 1 : SLICE;
    localparam int unsigned N    = WIDTH / SDIV;
    localparam int unsigned KW   = (N > 1) ? $clog2(N) : 1;
    localparam logic [KW-1:0] KLAST = KW'(N - 1);

    generate
        if ((SLICE == 0) || ((WIDTH % SDIV) != 0)) begin : g_bad_cfg
            $error("cselect_seq_adder: WIDTH must be a non-zero multiple of SLICE");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic             carry;
    logic [KW-1:0]    k;

    logic [SLICE-1:0] seg_a;
    logic [SLICE-1:0] seg_b;
    logic [SLICE-1:0] s0;
    logic [SLICE-1:0] s1;
    logic [SLICE-1:0] seg_sum;
    logic             c0;
    logic             c1;
    logic             seg_cout;
    logic             accept;
    logic             last;

    // Carry-select slice: both carry-in cases in parallel, registered carry picks one.
    // Operand registers shift right each RUN cycle so the current segment is always at the bottom.
    always_comb begin
        seg_a    = a_r[SLICE-1:0];
        seg_b    = b_r[SLICE-1:0];
        {c0, s0} = {1'b0, seg_a} + {1'b0, seg_b};
        {c1, s1} = {1'b0, seg_a} + {1'b0, seg_b} + (SLICE + 1)'(1);
        seg_sum  = carry ? s1 : s0;
        seg_cout = carry ? c1 : c0;
    end

    // Next-state and handshake outputs; in_ready is forced low while rst is asserted.
    always_comb begin
        state_nxt = state;
        in_ready  = (state == IDLE) && !rst;
        out_valid = (state == DONE);
        accept    = in_valid && in_ready;
        last      = (k == KLAST);
        unique case (state)
            IDLE:    if (accept)    state_nxt = RUN;
            RUN:     if (last)      state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Operand capture, per-segment sum write-back and carry chaining.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_r   <= '0;
            b_r   <= '0;
            carry <= 1'b0;
            k     <= '0;
            sum   <= '0;
            cout  <= 1'b0;
`ifdef CSELECT_SEQ_OVF_EN
            ovf   <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        a_r   <= a;
                        b_r   <= b;
                        carry <= cin;
                        k     <= '0;
                    end
                end
                RUN: begin
                    a_r                  <= a_r >> SLICE;
                    b_r                  <= b_r >> SLICE;
                    carry                <= seg_cout;
                    sum[k*SLICE +: SLICE] <= seg_sum;
                    k                    <= last ? '0 : k + KW'(1);
                    if (last) begin
                        cout <= seg_cout;
`ifdef CSELECT_SEQ_OVF_EN
                        // a^b^sum at the MSB recovers the carry into that bit.
                        ovf  <= seg_a[SLICE-1] ^ seg_b[SLICE-1] ^ seg_sum[SLICE-1] ^ seg_cout;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cselect_seq_adder.sv
// Self-checking bench for cselect_seq_adder with a queue-based scoreboard.
// Build with CSELECT_SEQ_OVF_EN defined to also exercise the ovf output.
module tb_cselect_seq_adder;

    localparam int unsigned WIDTH = 64;
    localparam int unsigned SLICE = 8;
    localparam int          N     = WIDTH / SLICE;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             cin = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] sum;
    logic             cout;
`ifdef CSELECT_SEQ_OVF_EN
    logic             ovf;
`endif

    typedef struct packed {
        logic [WIDTH-1:0] sum;
        logic             cout;
        logic             ovf;
    } exp_t;

    exp_t sb[$];
    int   passed = 0;
    int   total  = 0;

    cselect_seq_adder #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
`ifdef CSELECT_SEQ_OVF_EN
        .ovf       (ovf),
`endif
        .cout      (cout)
    );

    always #5 clk = ~clk;

    // Reference: full-width add; overflow from operand/result sign bits.
    function automatic exp_t model(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                                   input logic cv);
        exp_t           e;
        logic [WIDTH:0] t;
        t      = {1'b0, av} + {1'b0, bv} + {{WIDTH{1'b0}}, cv};
        e.sum  = t[WIDTH-1:0];
        e.cout = t[WIDTH];
        e.ovf  = (av[WIDTH-1] == bv[WIDTH-1]) && (t[WIDTH-1] != av[WIDTH-1]);
        return e;
    endfunction

    // Wait for in_ready, present one operand pair for one edge, push its expectation.
    task automatic send(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                        input logic cv, output bit ok);
        int n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        ok = in_ready;
        if (ok) begin
            a = av; b = bv; cin = cv; in_valid = 1'b1;
            @(posedge clk); #1;
            in_valid = 1'b0;
            sb.push_back(model(av, bv, cv));
        end
    endtask

    // Count edges until out_valid; -1 when the budget expires.
    task automatic wait_out(output int cyc);
        cyc = 0;
        while (!out_valid && cyc < 50) begin
            @(posedge clk); #1;
            cyc++;
        end
        if (!out_valid) cyc = -1;
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            total++; if (in_ready !== 1'b0) $display("FAIL reset_ready_low: got %b want 0", in_ready); else passed++;
        end
        rst = 1'b0;
        #1;
        total++; if (in_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", in_ready); else passed++;
        total++; if (out_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", out_valid); else passed++;
        total++; if (sum !== '0) $display("FAIL reset_sum: got %0h want 0", sum); else passed++;
        total++; if (cout !== 1'b0) $display("FAIL reset_cout: got %b want 0", cout); else passed++;
`ifdef CSELECT_SEQ_OVF_EN
        total++; if (ovf !== 1'b0) $display("FAIL reset_ovf: got %b want 0", ovf); else passed++;
`endif
    endtask

    task automatic test_basic();
        bit   ok;
        int   cyc;
        exp_t e;
        send(64'd998, 64'd128, 1'b0, ok);
        total++; if (!ok) begin $display("FAIL basic_accept: got no in_ready want accept"); return; end else passed++;
        wait_out(cyc);
        total++; if (cyc != N) $display("FAIL basic_latency: got %0d want %0d", cyc, N); else passed++;
        e = sb.pop_front();
        total++; if (sum !== e.sum) $display("FAIL basic_sum: got %0d want %0d", sum, e.sum); else passed++;
        total++; if (sum !== 64'd1126) $display("FAIL basic_sum_const: got %0d want 1126", sum); else passed++;
        total++; if (cout !== e.cout) $display("FAIL basic_cout: got %b want %b", cout, e.cout); else passed++;
        consume();
        total++; if (out_valid !== 1'b0) $display("FAIL basic_valid_drop: got %b want 0", out_valid); else passed++;
        total++; if (in_ready !== 1'b1) $display("FAIL basic_ready_back: got %b want 1", in_ready); else passed++;
    endtask

    task automatic test_ripple();
        bit   ok;
        int   cyc;
        exp_t e;
        send({WIDTH{1'b1}}, 64'd1, 1'b0, ok);
        total++; if (!ok) begin $display("FAIL ripple_accept: got no in_ready want accept"); return; end else passed++;
        wait_out(cyc);
        total++; if (cyc != N) $display("FAIL ripple_latency: got %0d want %0d", cyc, N); else passed++;
        e = sb.pop_front();
        total++; if (sum !== e.sum) $display("FAIL ripple_sum: got %0h want %0h", sum, e.sum); else passed++;
        total++; if (cout !== 1'b1) $display("FAIL ripple_cout: got %b want 1", cout); else passed++;
`ifdef CSELECT_SEQ_OVF_EN
        total++; if (ovf !== e.ovf) $display("FAIL ripple_ovf: got %b want %b", ovf, e.ovf); else passed++;
`endif
        consume();
        send('0, '0, 1'b1, ok);
        total++; if (!ok) begin $display("FAIL cin_accept: got no in_ready want accept"); return; end else passed++;
        wait_out(cyc);
        e = sb.pop_front();
        total++; if (sum !== e.sum) $display("FAIL cin_sum: got %0h want %0h", sum, e.sum); else passed++;
        total++; if (cout !== e.cout) $display("FAIL cin_cout: got %b want %b", cout, e.cout); else passed++;
        consume();
    endtask

`ifdef CSELECT_SEQ_OVF_EN
    task automatic test_ovf();
        bit   ok;
        int   cyc;
        exp_t e;
        send(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, ok);
        total++; if (!ok) begin $display("FAIL ovf_accept: got no in_ready want accept"); return; end else passed++;
        wait_out(cyc);
        e = sb.pop_front();
        total++; if (sum !== 64'h8000_0000_0000_0000) $display("FAIL ovf_sum: got %0h want 8000000000000000", sum); else passed++;
        total++; if (cout !== e.cout) $display("FAIL ovf_cout: got %b want %b", cout, e.cout); else passed++;
        total++; if (ovf !== 1'b1) $display("FAIL ovf_flag: got %b want 1", ovf); else passed++;
        consume();
    endtask
`endif

    task automatic test_backpressure();
        bit   ok;
        int   cyc;
        int   bad;
        exp_t e;
        send({$urandom, $urandom}, {$urandom, $urandom}, 1'b1, ok);
        total++; if (!ok) begin $display("FAIL bp_accept: got no in_ready want accept"); return; end else passed++;
        wait_out(cyc);
        total++; if (cyc != N) $display("FAIL bp_latency: got %0d want %0d", cyc, N); else passed++;
        e = sb.pop_front();
        repeat (5) begin
            a = {$urandom, $urandom}; b = {$urandom, $urandom}; cin = 1'b0; in_valid = 1'b1;
            @(posedge clk); #1;
            total++; if (out_valid !== 1'b1) $display("FAIL bp_valid_hold: got %b want 1", out_valid); else passed++;
            total++; if (in_ready !== 1'b0) $display("FAIL bp_ready_low: got %b want 0", in_ready); else passed++;
            total++; if (sum !== e.sum) $display("FAIL bp_sum_hold: got %0h want %0h", sum, e.sum); else passed++;
            total++; if (cout !== e.cout) $display("FAIL bp_cout_hold: got %b want %b", cout, e.cout); else passed++;
        end
        in_valid = 1'b0;
        consume();
        total++; if (out_valid !== 1'b0) $display("FAIL bp_valid_drop: got %b want 0", out_valid); else passed++;
        total++; if (in_ready !== 1'b1) $display("FAIL bp_ready_back: got %b want 1", in_ready); else passed++;
        total++; if (sum !== e.sum) $display("FAIL bp_sum_after: got %0h want %0h", sum, e.sum); else passed++;
        bad = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b0) bad++;
        end
        total++; if (bad != 0) $display("FAIL bp_ignored_ops: got %0d valid cycles want 0", bad); else passed++;
    endtask

    task automatic test_mid_reset();
        bit   ok;
        int   cyc;
        int   bad;
        exp_t e;
        send({$urandom, $urandom}, {$urandom, $urandom}, 1'b0, ok);
        total++; if (!ok) begin $display("FAIL mr_accept: got no in_ready want accept"); return; end else passed++;
        void'(sb.pop_back());
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        total++; if (out_valid !== 1'b0) $display("FAIL mr_valid: got %b want 0", out_valid); else passed++;
        total++; if (sum !== '0) $display("FAIL mr_sum: got %0h want 0", sum); else passed++;
        total++; if (cout !== 1'b0) $display("FAIL mr_cout: got %b want 0", cout); else passed++;
        total++; if (in_ready !== 1'b1) $display("FAIL mr_ready: got %b want 1", in_ready); else passed++;
        bad = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b0) bad++;
        end
        total++; if (bad != 0) $display("FAIL mr_no_result: got %0d valid cycles want 0", bad); else passed++;
        send(64'd9998, 64'd9028, 1'b0, ok);
        total++; if (!ok) begin $display("FAIL mr2_accept: got no in_ready want accept"); return; end else passed++;
        wait_out(cyc);
        total++; if (cyc != N) $display("FAIL mr2_latency: got %0d want %0d", cyc, N); else passed++;
        e = sb.pop_front();
        total++; if (sum !== e.sum) $display("FAIL mr2_sum: got %0d want %0d", sum, e.sum); else passed++;
        total++; if (cout !== e.cout) $display("FAIL mr2_cout: got %b want %b", cout, e.cout); else passed++;
        consume();
    endtask

    task automatic test_back_to_back();
        bit               ok;
        int               cyc;
        exp_t             e;
        logic [WIDTH-1:0] av;
        logic [WIDTH-1:0] bv;
        for (int i = 0; i < 8; i++) begin
            av = {$urandom, $urandom};
            bv = (i % 2 == 0) ? ~av : {$urandom, $urandom};
            send(av, bv, 1'($urandom_range(0, 1)), ok);
            total++; if (!ok) begin $display("FAIL b2b_accept: got no in_ready want accept (op %0d)", i); return; end else passed++;
            wait_out(cyc);
            total++; if (cyc != N) $display("FAIL b2b_latency: got %0d want %0d (op %0d)", cyc, N, i); else passed++;
            e = sb.pop_front();
            total++; if (sum !== e.sum) $display("FAIL b2b_sum: got %0h want %0h (op %0d)", sum, e.sum, i); else passed++;
            total++; if (cout !== e.cout) $display("FAIL b2b_cout: got %b want %b (op %0d)", cout, e.cout, i); else passed++;
`ifdef CSELECT_SEQ_OVF_EN
            total++; if (ovf !== e.ovf) $display("FAIL b2b_ovf: got %b want %b (op %0d)", ovf, e.ovf, i); else passed++;
`endif
            consume();
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_ripple();
`ifdef CSELECT_SEQ_OVF_EN
        test_ovf();
`endif
        test_backpressure();
        test_mid_reset();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
